// File: rtl/prince_hs_wrap.sv
// Valid/ready wrapper around the two-cycle PRINCE core: derives the whitening
// keys, drives the core from registers, waits CORE_LAT cycles and post-whitens.
module prince_hs_wrap #(
    parameter int unsigned CORE_LAT = 2,
    parameter logic [63:0] ALPHA    = 64'hC0AC29B7C97C50DD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [63:0]   in_data,
    input  logic [127:0]  in_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          busy,
    output logic [63:0]   core_pt,
    output logic [63:0]   core_wk,
    output logic [63:0]   core_key,
    input  logic [63:0]   core_ct
);

    localparam int unsigned CNT_W = $clog2(CORE_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [63:0]      pt_reg, wk_reg, key_reg, postw_reg, out_data_reg;
    logic             out_valid_reg;
    logic             accept, capture, release_out;

    logic [63:0] k0, k1, k0p, kc, kin, kout;
    logic [63:0] pt_next, wk_next, postw_next;

    // k0' = ROR1(k0) with the new LSB folded with the old MSB
    assign k0   = in_key[127:64];
    assign k1   = in_key[63:0];
    assign k0p  = {k0[0], k0[63:2], k0[1] ^ k0[63]};
    assign kc   = in_mode ? (k1 ^ ALPHA) : k1;
    assign kin  = in_mode ? k0p : k0;
    assign kout = in_mode ? k0 : k0p;

    assign pt_next    = in_data ^ kin ^ kc;
    assign wk_next    = kc ^ ALPHA;
    assign postw_next = kout ^ wk_next;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        in_ready    = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // a simultaneous in_valid waits for the IDLE cycle that follows
                if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pt_reg        <= '0;
            wk_reg        <= '0;
            key_reg       <= '0;
            postw_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                pt_reg    <= pt_next;
                wk_reg    <= wk_next;
                key_reg   <= kc;
                postw_reg <= postw_next;
            end
            if (capture) begin
                out_data_reg  <= core_ct ^ postw_reg;
                out_valid_reg <= 1'b1;
            end else if (release_out) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign core_pt   = pt_reg;
    assign core_wk   = wk_reg;
    assign core_key  = key_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_prince_hs_wrap.sv
// Bench for prince_hs_wrap: a behavioural PRINCE core sits on the core_* ports
// and results are compared with a full-cipher reference computed in the bench.
module tb_prince_hs_wrap;

    localparam int          CORE_LAT = 2;
    localparam logic [63:0] ALPHA    = 64'hC0AC29B7C97C50DD;
    localparam logic [63:0] KAT1     = 64'h818665AA0D02DFDA;

    logic         clk, reset, in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [63:0]  in_data, out_data, core_pt, core_wk, core_key, core_ct;
    logic [127:0] in_key;
    logic [63:0]  st_pt, st_key;
    int           n_checks = 0;
    int           n_fail   = 0;

    prince_hs_wrap #(.CORE_LAT(CORE_LAT), .ALPHA(ALPHA)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
        .core_pt(core_pt), .core_wk(core_wk), .core_key(core_key), .core_ct(core_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- PRINCE reference ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: return 4'hB; 4'h1: return 4'hF; 4'h2: return 4'h3; 4'h3: return 4'h2;
            4'h4: return 4'hA; 4'h5: return 4'hC; 4'h6: return 4'h9; 4'h7: return 4'h1;
            4'h8: return 4'h6; 4'h9: return 4'h7; 4'hA: return 4'h8; 4'hB: return 4'h0;
            4'hC: return 4'hE; 4'hD: return 4'h5; 4'hE: return 4'hD; default: return 4'h4;
        endcase
    endfunction

    function automatic logic [3:0] sbinv(input logic [3:0] x);
        case (x)
            4'h0: return 4'hB; 4'h1: return 4'h7; 4'h2: return 4'h3; 4'h3: return 4'h2;
            4'h4: return 4'hF; 4'h5: return 4'hD; 4'h6: return 4'h8; 4'h7: return 4'h9;
            4'h8: return 4'hA; 4'h9: return 4'h6; 4'hA: return 4'h4; 4'hB: return 4'h0;
            4'hC: return 4'h5; 4'hD: return 4'hE; 4'hE: return 4'hC; default: return 4'h1;
        endcase
    endfunction

    function automatic logic [63:0] slayer(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++)
            y[4*n +: 4] = inv ? sbinv(x[4*n +: 4]) : sb(x[4*n +: 4]);
        return y;
    endfunction

    // 16-bit M-hat block: each output bit is the XOR of three same-position input bits
    function automatic logic [15:0] mhat(input logic [15:0] x, input int sel);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++)
                for (int j = 0; j < 4; j++)
                    if (((b - 1 - j + sel) & 3) != i) y[4*i+b] = y[4*i+b] ^ x[4*j+b];
        return y;
    endfunction

    function automatic logic [63:0] mprime(input logic [63:0] x);
        return {mhat(x[63:48], 0), mhat(x[47:32], 1), mhat(x[31:16], 1), mhat(x[15:0], 0)};
    endfunction

    function automatic logic [63:0] shrows(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        int c, r, src;
        y = '0;
        for (int k = 0; k < 16; k++) begin
            c   = k / 4;
            r   = k % 4;
            src = inv ? 4 * ((c - r) & 3) + r : 4 * ((c + r) & 3) + r;
            y[63-4*k -: 4] = x[63-4*src -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] rc(input int i);
        case (i)
            0:  return 64'h0;
            1:  return 64'h13198A2E03707344;
            2:  return 64'hA4093822299F31D0;
            3:  return 64'h082EFA98EC4E6C89;
            4:  return 64'h452821E638D01377;
            5:  return 64'hBE5466CF34E90C6C;
            11: return ALPHA;
            default: return rc(11 - i) ^ ALPHA;
        endcase
    endfunction

    // PRINCEcore without its first and last key additions
    function automatic logic [63:0] inner(input logic [63:0] xin, input logic [63:0] k);
        logic [63:0] x;
        x = xin;
        for (int i = 1; i <= 5; i++) x = shrows(mprime(slayer(x, 0)), 0) ^ rc(i) ^ k;
        x = slayer(mprime(slayer(x, 0)), 1);
        for (int i = 6; i <= 10; i++) x = slayer(mprime(shrows(x ^ k ^ rc(i), 1)), 1);
        return x;
    endfunction

    function automatic logic [63:0] prince_ref(input logic [63:0] m, input logic [63:0] k0,
                                               input logic [63:0] k1, input logic dec);
        logic [63:0] k0p, kk;
        k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
        if (!dec) return inner(m ^ k0 ^ rc(0) ^ k1, k1) ^ k1 ^ rc(11) ^ k0p;
        kk = k1 ^ ALPHA;
        return inner(m ^ k0p ^ kk, kk) ^ kk ^ rc(11) ^ k0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Core model: one input register stage, so ct is valid CORE_LAT edges after accept
    always @(posedge clk) begin
        st_pt  <= core_pt;
        st_key <= core_key;
    end
    always_comb core_ct = inner(st_pt, st_key);

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic mode, input logic [63:0] data, input logic [127:0] key,
                             output logic [63:0] got, output int lat,
                             output logic [63:0] pt_seen, output logic [63:0] wk_seen,
                             output logic [63:0] key_seen);
        in_mode  = mode;
        in_data  = data;
        in_key   = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        pt_seen  = core_pt;
        wk_seen  = core_wk;
        key_seen = core_key;
        in_data  = rnd64();
        in_key   = {rnd64(), rnd64()};
        in_mode  = ~mode;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        got = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if ({core_pt, core_wk, core_key} !== 192'h0) begin n_fail++; $display("FAIL reset_core: got %h %h %h want 0", core_pt, core_wk, core_key); end
    endtask

    task automatic test_kat();
        logic [63:0]  tv_d [5];
        logic [127:0] tv_k [5];
        logic         tv_m [5];
        logic [63:0]  tv_e [5];
        logic [63:0]  got, pt_s, wk_s, key_s, kc, k0, k0p;
        int           lat;
        tv_m[0] = 0; tv_d[0] = 64'h0;                tv_k[0] = 128'h0;                                  tv_e[0] = KAT1;
        tv_m[1] = 0; tv_d[1] = 64'hFFFFFFFFFFFFFFFF; tv_k[1] = 128'h0;                                  tv_e[1] = 64'h604AE6CA03C20ADA;
        tv_m[2] = 0; tv_d[2] = 64'h0;                tv_k[2] = {64'hFFFFFFFFFFFFFFFF, 64'h0};           tv_e[2] = 64'h9FB51935FC3DF524;
        tv_m[3] = 0; tv_d[3] = 64'h0123456789ABCDEF; tv_k[3] = {64'h0, 64'hFEDCBA9876543210};           tv_e[3] = 64'hAE25AD3CA8FA9CCF;
        tv_m[4] = 1; tv_d[4] = 64'hAE25AD3CA8FA9CCF; tv_k[4] = {64'h0, 64'hFEDCBA9876543210};           tv_e[4] = 64'h0123456789ABCDEF;
        for (int i = 0; i < 5; i++) begin
            run_block(tv_m[i], tv_d[i], tv_k[i], got, lat, pt_s, wk_s, key_s);
            k0  = tv_k[i][127:64];
            k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
            kc  = tv_m[i] ? tv_k[i][63:0] ^ ALPHA : tv_k[i][63:0];
            $display("kat %0d mode=%0d data=%h -> %h lat=%0d", i, tv_m[i], tv_d[i], got, lat);
            n_checks++; if (lat != CORE_LAT) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", i, lat, CORE_LAT); end
            n_checks++; if (got !== tv_e[i]) begin n_fail++; $display("FAIL kat%0d_data: got %h want %h", i, got, tv_e[i]); end
            n_checks++; if (key_s !== kc) begin n_fail++; $display("FAIL kat%0d_core_key: got %h want %h", i, key_s, kc); end
            n_checks++; if (wk_s !== (kc ^ ALPHA)) begin n_fail++; $display("FAIL kat%0d_core_wk: got %h want %h", i, wk_s, kc ^ ALPHA); end
            n_checks++; if (pt_s !== (tv_d[i] ^ kc ^ (tv_m[i] ? k0p : k0))) begin n_fail++; $display("FAIL kat%0d_core_pt: got %h want %h", i, pt_s, tv_d[i] ^ kc ^ (tv_m[i] ? k0p : k0)); end
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL kat%0d_release: got valid=%b ready=%b want 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_random();
        logic [63:0]  d, got, exp_v, pt_s, wk_s, key_s;
        logic [127:0] k;
        logic         m;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            d = rnd64();
            k = {rnd64(), rnd64()};
            m = 1'($urandom_range(0, 1));
            exp_v = prince_ref(d, k[127:64], k[63:0], m);
            run_block(m, d, k, got, lat, pt_s, wk_s, key_s);
            $display("rand %0d mode=%0d data=%h -> %h", i, m, d, got);
            n_checks++; if (lat != CORE_LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, CORE_LAT); end
            n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand%0d_data: got %h want %h", i, got, exp_v); end
        end
    endtask

    task automatic test_backpressure();
        int w;
        in_mode = 1'b0; in_data = 64'h0; in_key = 128'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin tick(); w++; end
        n_checks++; if (w != CORE_LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", w, CORE_LAT); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = rnd64();
            in_key   = {rnd64(), rnd64()};
            tick();
            $display("bp cycle %0d valid=%b data=%h ready=%b", c, out_valid, out_data, in_ready);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid: got %b want 1", c, out_valid); end
            n_checks++; if (out_data !== KAT1) begin n_fail++; $display("FAIL bp%0d_data: got %h want %h", c, out_data, KAT1); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready: got %b want 0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", out_valid, busy); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] got, pt_s, wk_s, key_s;
        int          lat, seen;
        in_mode = 1'b0; in_data = 64'h0123456789ABCDEF; in_key = {64'h0, 64'hFEDCBA9876543210};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if ({core_pt, core_wk, core_key} !== 192'h0) begin n_fail++; $display("FAIL rst_mid_core: got %h %h %h want 0", core_pt, core_wk, core_key); end
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got busy=%b valid=%b want 0 0", busy, out_valid); end
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", seen); end
        run_block(1'b0, 64'h0, 128'h0, got, lat, pt_s, wk_s, key_s);
        $display("after reset block -> %h lat=%0d", got, lat);
        n_checks++; if (lat != CORE_LAT) begin n_fail++; $display("FAIL rst_mid_latency: got %0d want %0d", lat, CORE_LAT); end
        n_checks++; if (got !== KAT1) begin n_fail++; $display("FAIL rst_mid_data: got %h want %h", got, KAT1); end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  d [4];
        logic [127:0] k [4];
        logic         m [4];
        logic [63:0]  exp_q [$];
        logic [63:0]  e;
        int           t [4];
        int           idx, nres, extra;
        logic         acc;
        for (int i = 0; i < 4; i++) begin
            d[i] = rnd64();
            k[i] = {rnd64(), rnd64()};
            m[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; nres = 0;
        in_mode = m[0]; in_data = d[0]; in_key = k[0];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && nres < 4; cyc++) begin
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(prince_ref(in_data, in_key[127:64], in_key[63:0], in_mode));
            if (out_valid) begin
                $display("b2b result %0d at cycle %0d data=%h", nres, cyc, out_data);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b%0d_spurious: got %h want no transfer", nres, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL b2b%0d_data: got %h want %h", nres, out_data, e); end
                end
                t[nres] = cyc;
                nres++;
            end
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_mode = m[idx]; in_data = d[idx]; in_key = k[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_checks++; if (nres != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results want 4", nres); end
        for (int i = 1; i < nres; i++) begin
            n_checks++;
            if (t[i] - t[i-1] != CORE_LAT + 2) begin n_fail++; $display("FAIL b2b%0d_spacing: got %0d want %0d", i, t[i] - t[i-1], CORE_LAT + 2); end
        end
        in_valid = 1'b0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) extra++;
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (extra != 0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got %0d extra, ready=%b want 0 extra, ready=1", extra, in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        test_reset();
        test_kat();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
